// File: rtl/radix4_inv_bfly.sv
// radix4_inv_bfly: sequential radix-4 inverse (+j) butterfly with 1/4 scaling over valid/ready streams
module radix4_inv_bfly #(
  parameter int W = 45
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [1:0]   out_idx
);
  typedef enum logic [1:0] {COLLECT, CALC, EMIT} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [W-1:0] xr_q [4], xi_q [4], xr_d [4], xi_d [4];
  logic [W-1:0] yr_q [4], yi_q [4], yr_d [4], yi_d [4];
  logic signed [W+1:0] er [4], ei [4], sr [4], si [4];
  assign in_ready = state_q == COLLECT;
  assign out_valid = state_q == EMIT;
  assign out_re = out_valid ? yr_q[cnt_q] : '0;
  assign out_im = out_valid ? yi_q[cnt_q] : '0;
  assign out_idx = out_valid ? cnt_q : 2'd0;
  // two guard bits make every sum exact before the divide-by-4
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      er[i] = {{2{xr_q[i][W-1]}}, xr_q[i]};
      ei[i] = {{2{xi_q[i][W-1]}}, xi_q[i]};
    end
    sr[0] = er[0] + er[1] + er[2] + er[3];
    si[0] = ei[0] + ei[1] + ei[2] + ei[3];
    sr[1] = er[0] - ei[1] - er[2] + ei[3];
    si[1] = ei[0] + er[1] - ei[2] - er[3];
    sr[2] = er[0] - er[1] + er[2] - er[3];
    si[2] = ei[0] - ei[1] + ei[2] - ei[3];
    sr[3] = er[0] + ei[1] - er[2] - ei[3];
    si[3] = ei[0] - er[1] - ei[2] + er[3];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    xr_d = xr_q;
    xi_d = xi_q;
    yr_d = yr_q;
    yi_d = yi_q;
    if (in_valid && in_ready) begin
      xr_d[cnt_q] = in_re;
      xi_d[cnt_q] = in_im;
      cnt_d = cnt_q + 2'd1;
      state_d = cnt_q == 2'd3 ? CALC : COLLECT;
    end
    if (state_q == CALC) begin
      for (int i = 0; i < 4; i++) begin
        yr_d[i] = W'(sr[i] >>> 2);
        yi_d[i] = W'(si[i] >>> 2);
      end
      state_d = EMIT;
    end
    if (out_valid && out_ready) begin
      cnt_d = cnt_q + 2'd1;
      state_d = cnt_q == 2'd3 ? COLLECT : EMIT;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= COLLECT;
      cnt_q <= '0;
      for (int i = 0; i < 4; i++) begin
        xr_q[i] <= '0;
        xi_q[i] <= '0;
        yr_q[i] <= '0;
        yi_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      xr_q <= xr_d;
      xi_q <= xi_d;
      yr_q <= yr_d;
      yi_q <= yi_d;
    end
endmodule

// File: tb/tb_radix4_inv_bfly.sv
// tb_radix4_inv_bfly: randomized and directed checks of radix4_inv_bfly against a rotation-based reference model
module tb_radix4_inv_bfly;
  localparam int W = 45;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready;
  logic [W-1:0] in_re = '0, in_im = '0, out_re, out_im;
  logic [1:0] out_idx;
  typedef struct {longint re; longint im; int idx;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  longint cyc = 0, last0 = -1;
  bit track = 0, rdy_rand = 0, rdy_force = 0;
  longint br [4], bi [4], mr [4], mi [4], er [4], ei [4];
  radix4_inv_bfly #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input longint a, input longint e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, a, e);
    end
  endtask
  // X_k = sum_n x_n * j^(n*k), then floor-divide by 4
  task automatic bfly();
    for (int k = 0; k < 4; k++) begin
      longint ar = 0, ai = 0;
      for (int n = 0; n < 4; n++) begin
        longint tr = br[n], ti = bi[n], t;
        for (int m = 0; m < (n * k) % 4; m++) begin
          t = tr;
          tr = -ti;
          ti = t;
        end
        ar += tr;
        ai += ti;
      end
      mr[k] = ar >>> 2;
      mi[k] = ai >>> 2;
    end
  endtask
  task automatic push_model();
    bfly();
    for (int k = 0; k < 4; k++) q.push_back('{re: mr[k], im: mi[k], idx: k});
  endtask
  function automatic longint rnd45();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: return 64'sd17592186044415;
      1: return -64'sd17592186044416;
      default: return longint'($signed(t[W-1:0]));
    endcase
  endfunction
  task automatic send_block(input bit thr);
    int n = 0, t = 0;
    while (n < 4) begin
      in_re = br[n][W-1:0];
      in_im = bi[n][W-1:0];
      in_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) begin
        n++;
        if (n == 4) push_model();
      end
      t++;
      if (t > 300) begin
        chk("in_timeout", n, 4);
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
  endtask
  task automatic wait_drain();
    int t = 0;
    while (q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic directed(input string nm);
    bfly();
    for (int k = 0; k < 4; k++) begin
      chk({nm, "_model_re"}, mr[k], er[k]);
      chk({nm, "_model_im"}, mi[k], ei[k]);
    end
    send_block(0);
    wait_drain();
  endtask
  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end
  initial begin : mon
    longint pre = 0, pim = 0;
    int pidx = 0;
    bit hold = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0;
        continue;
      end
      chk("excl", longint'(in_ready && out_valid), 0);
      if (hold) begin
        chk("hold_valid", longint'(out_valid), 1);
        chk("hold_re", longint'($signed(out_re)), pre);
        chk("hold_im", longint'($signed(out_im)), pim);
        chk("hold_idx", longint'(out_idx), pidx);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_re", longint'($signed(out_re)), e.re);
          chk("out_im", longint'($signed(out_im)), e.im);
          chk("out_idx", longint'(out_idx), e.idx);
          if (e.idx == 0 && track) begin
            if (last0 >= 0) chk("period", cyc - last0, 9);
            last0 = cyc;
          end
        end
      end
      hold = out_valid && !out_ready;
      pre = longint'($signed(out_re));
      pim = longint'($signed(out_im));
      pidx = int'(out_idx);
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
  initial begin
    longint fs;
    bit pv [6];
    int got, n, t;
    fs = 64'sd17592186044415;
    pv = '{1, 0, 1, 1, 0, 1};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_re", longint'(out_re), 0);
    chk("rst_out_im", longint'(out_im), 0);
    chk("rst_out_idx", longint'(out_idx), 0);
    @(posedge clk);
    #2 rst = 0;
    rdy_force = 1;
    @(posedge clk);
    #1;
    br = '{4, 0, 0, 0}; bi = '{0, 0, 0, 0};
    er = '{1, 1, 1, 1}; ei = '{0, 0, 0, 0};
    directed("impulse");
    br = '{0, 0, 0, 0}; bi = '{0, 4, 0, 0};
    er = '{0, -1, 0, 1}; ei = '{1, 0, -1, 0};
    directed("rotation");
    br = '{-1, 0, 0, 0}; bi = '{3, 0, 0, 0};
    er = '{-1, -1, -1, -1}; ei = '{0, 0, 0, 0};
    directed("floor");
    br = '{fs, fs, fs, fs}; bi = '{-fs - 1, -fs - 1, -fs - 1, -fs - 1};
    er = '{fs, 0, 0, 0}; ei = '{-fs - 1, 0, 0, 0};
    directed("fullscale");
    rdy_force = 0;
    for (int k = 0; k < 4; k++) begin
      br[k] = rnd45();
      bi[k] = rnd45();
    end
    got = 0;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk);
      #1;
      in_valid = pv[s];
      in_re = br[got < 4 ? got : 3][W-1:0];
      in_im = bi[got < 4 ? got : 3][W-1:0];
      @(negedge clk);
      if (in_valid) chk("hs_ready_collect", longint'(in_ready), 1);
      if (in_valid && in_ready) got++;
    end
    chk("hs_accepted", got, 4);
    push_model();
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    chk("hs_ready_drop", longint'(in_ready), 0);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_valid", longint'(out_valid), 1);
      chk("stall_idx", longint'(out_idx), 0);
      chk("stall_in_ready", longint'(in_ready), 0);
    end
    rdy_force = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("burst_valid", longint'(out_valid && out_ready), 1);
      chk("burst_idx", longint'(out_idx), k);
    end
    @(negedge clk);
    chk("burst_in_ready", longint'(in_ready), 1);
    chk("burst_out_valid", longint'(out_valid), 0);
    chk("burst_queue", q.size(), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      br[k] = rnd45();
      bi[k] = rnd45();
    end
    send_block(0);
    n = 0;
    t = 0;
    while (n < 2 && t < 50) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
      t++;
    end
    chk("rst_mid_outputs", n, 2);
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("arst_out_valid", longint'(out_valid), 0);
    chk("arst_out_re", longint'(out_re), 0);
    chk("arst_out_im", longint'(out_im), 0);
    chk("arst_out_idx", longint'(out_idx), 0);
    chk("arst_in_ready", longint'(in_ready), 1);
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 0;
    @(posedge clk);
    #1;
    br = '{8, 0, 0, 0}; bi = '{0, 0, 0, 0};
    er = '{2, 2, 2, 2}; ei = '{0, 0, 0, 0};
    directed("after_reset");
    last0 = -1;
    track = 1;
    for (int b = 0; b < 1000; b++) begin
      if (b == 20) begin
        wait_drain();
        track = 0;
        rdy_rand = 1;
      end
      for (int k = 0; k < 4; k++) begin
        br[k] = rnd45();
        bi[k] = rnd45();
      end
      send_block(b >= 20);
    end
    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/radix4_inv_bfly.md
# radix4_inv_bfly

Sequential radix-4 inverse butterfly for the IFFT path: collects four complex samples over a valid/ready input stream, computes the inverse (+j rotation) radix-4 butterfly with 1/4 scaling, and returns the four results over a valid/ready output stream. It pairs with the combinational forward radix-4 butterfly on the FFT side. The 1/4 scaling means two cascaded forward/inverse stages restore the original amplitude. Data words are 45-bit two's complement, matching the FFT datapath.

## Interface
- `W`, 45: real/imag word width (signed two's complement)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input sample valid
- `in_ready`  out  1  block accepts input sample
- `in_re`, `in_im`  in  W each  input sample real/imag
- `out_valid`  out  1  output sample valid
- `out_ready`  in  1  downstream accepts output sample
- `out_re`, `out_im`  out  W each  output sample real/imag
- `out_idx`  out  2  butterfly output index k (0..3) of current output sample

## Operation
- FSM states: COLLECT, CALC, EMIT. Reset state COLLECT.
- COLLECT:
  - `in_ready`=1.
  - Each transfer (`in_valid & in_ready`) stores the sample to slot `cnt` (x0..x3) and increments the 2-bit `cnt`.
  - Transfer with `cnt`=3 -> CALC, `cnt` wraps to 0.
- CALC (exactly 1 cycle): `in_ready`=0; register all four results -> EMIT.
- EMIT:
  - `out_valid`=1; `out_re`/`out_im`/`out_idx` present result `cnt`.
  - Each transfer (`out_valid & out_ready`) increments `cnt`.
  - Transfer with `cnt`=3 -> COLLECT.
  - `in_ready`=0 throughout EMIT; no input is accepted until the last output is taken.
- Arithmetic (rN/iN = real/imag of xN), full-precision sums sign-extended to W+2 bits:
  - X0 = (r0+r1+r2+r3, i0+i1+i2+i3)
  - X1 = (r0−i1−r2+i3, i0+r1−i2−r3)
  - X2 = (r0−r1+r2−r3, i0−i1+i2−i3)
  - X3 = (r0+i1−r2−i3, i0−r1−i2+r3)
  - Output = sum[W+1:2], i.e. arithmetic shift right by 2 (floor, no rounding). No overflow is possible; no saturation logic.
- Output data and index are held stable while `out_valid` is high and `out_ready` is low.
- `in_*` data is ignored when `in_valid`=0 or `in_ready`=0.

## Timing
- Reset (async assert, registers cleared immediately):
  - state COLLECT, `cnt`=0
  - `in_ready`=1, `out_valid`=0
  - `out_re`=`out_im`=0, `out_idx`=0
  - sample and result registers cleared
- Reset mid-operation (any state) discards the partial or pending block; the first input after release is x0.
- Latency: 4th input transferred on edge E -> CALC during cycle E..E+1 -> `out_valid`=1 after edge E+1. The earliest output transfer (X0) is at edge E+2.
- Minimum block period: 9 cycles (4 in + 1 calc + 4 out) with `in_valid`=`out_ready`=1 throughout.
- `in_ready` and `out_valid` are registered-state decodes, never both 1 in the same cycle.
- `in_ready` does not depend combinationally on `out_ready`; `out_valid` does not depend combinationally on `in_valid`.
- Gaps (`in_valid`=0 or `out_ready`=0) stall the counter without losing data.

## Test plan
- Impulse at x0: x0=(4,0), x1..x3=(0,0) -> outputs k=0..3 all (1,0), `out_idx` 0,1,2,3 in order.
- Rotation direction: x1=(0,4), others 0 -> X0=(0,1), X1=(−1,0), X2=(0,−1), X3=(1,0). Checks the +j direction against the forward butterfly.
- Scaling/floor: x0=(−1,3), others 0 -> all outputs (−1,0). Full-scale: all xN=(2^44−1, −2^44) -> X0=(2^44−1, −2^44), X1..X3=(0,0), no wrap.
- Handshake/stall:
  - Inputs with `in_valid` toggling 1,0,1,1,0,1: 4 accepted, `in_ready` drops the cycle after the 4th transfer.
  - Hold `out_ready`=0 for 5 cycles in EMIT: X0 and `out_idx`=0 stable, `in_ready`=0.
  - Release `out_ready`: 4 outputs on 4 consecutive edges, then `in_ready`=1.
- Reset mid-EMIT: after the 2nd output, assert `rst` asynchronously -> `out_valid`=0, outputs 0, `in_ready`=1 immediately. A fresh block with x0=(8,0), x1..x3=(0,0) yields all outputs (2,0).
- Back-to-back random blocks vs. a reference model: 1000 blocks with random 45-bit inputs and random valid/ready -> bit-exact match, 9-cycle period when unthrottled.
